// File: rtl/icache_line_refill.sv
// Instruction-cache line refill: fetches an aligned 4 x 16-bit line and strobes it to the cache.
// Optional watchdog abort per beat is enabled by defining REFILL_TIMEOUT_EN.
module icache_line_refill #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss,
    input  logic [15:0] miss_addr,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic [63:0] dataLine,
    output logic        line_valid,
    output logic [9:0]  line_tag,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t     state;
    logic [1:0] beat;

`ifdef REFILL_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            dataLine   <= '0;
            line_valid <= 1'b0;
            line_tag   <= '0;
            busy       <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
            wait_cnt   <= '0;
            err        <= 1'b0;
`endif
        end else begin
            line_valid <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
            err        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (miss) begin
                        // mem_addr doubles as the latched base; it advances by one word per beat
                        mem_addr <= miss_addr & 16'hFFF8;
                        line_tag <= miss_addr[15:6];
                        beat     <= '0;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= FETCH;
`ifdef REFILL_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        // word 0 lands in the top 16 bits of the line
                        dataLine[{~beat, 4'b0000} +: 16] <= mem_data;
`ifdef REFILL_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (beat == 2'd3) begin
                            mem_rd     <= 1'b0;
                            line_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            beat     <= beat + 2'd1;
                            mem_addr <= mem_addr + 16'd2;
                        end
                    end
`ifdef REFILL_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LIMIT) begin
                        err    <= 1'b1;
                        mem_rd <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_line_refill.sv
// Self-checking bench for icache_line_refill: memory responder with per-beat wait states,
// expected lines queued at miss time and compared when line_valid strobes.
module tb_icache_line_refill;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss;
    logic [15:0] miss_addr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic [63:0] dataLine;
    logic        line_valid;
    logic [9:0]  line_tag;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_line_q[$];
    logic [9:0]  exp_tag_q[$];

    int waits[4];
    bit stall;

    icache_line_refill #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n), .miss(miss), .miss_addr(miss_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .dataLine(dataLine), .line_valid(line_valid), .line_tag(line_tag),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: data = 0xA000 + address, with waits[beat] stall cycles before each ack.
    initial begin
        int waited;
        waited   = 0;
        mem_ack  = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_rd && !stall) begin
                if (waited < waits[mem_addr[2:1]]) begin
                    mem_ack = 1'b0;
                    waited++;
                end else begin
                    mem_ack  = 1'b1;
                    mem_data = 16'hA000 + mem_addr;
                    waited   = 0;
                end
            end else begin
                mem_ack = 1'b0;
                if (!mem_rd) waited = 0;
            end
        end
    end

    task automatic start_miss(input logic [15:0] a, input bit push);
        logic [15:0] b;
        logic [15:0] w0, w1, w2, w3;
        miss      = 1'b1;
        miss_addr = a;
        if (push) begin
            b  = a & 16'hFFF8;
            w0 = 16'hA000 + b;
            w1 = 16'hA000 + b + 16'd2;
            w2 = 16'hA000 + b + 16'd4;
            w3 = 16'hA000 + b + 16'd6;
            exp_line_q.push_back({w0, w1, w2, w3});
            exp_tag_q.push_back(a[15:6]);
        end
    endtask

    // Follows one refill from the current negedge until line_valid, checking timing and addresses.
    task automatic run_line(input int exp_first_rd, input int exp_lat, input logic [15:0] base,
                            input bit chain, input logic [15:0] next_addr, input int exp_hold);
        int n, first_rd, hold;
        bit got;
        logic [15:0] seen[$];
        logic [63:0] el;
        logic [9:0]  et;
        logic [15:0] ea;
        n = 0; first_rd = -1; hold = 0; got = 1'b0;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            if (first_rd < 0 && mem_rd) begin
                first_rd  = n;
                miss_addr = ~miss_addr;
            end
            if (mem_rd && mem_addr == base + 16'd2) hold++;
            if (mem_rd && mem_ack) seen.push_back(mem_addr);
            if (line_valid) begin
                got = 1'b1;
                checks++;
                if (exp_line_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_line: line_valid with empty scoreboard, dataLine=%h", dataLine);
                end else begin
                    el = exp_line_q.pop_front();
                    et = exp_tag_q.pop_front();
                    if (dataLine !== el) begin
                        errors++;
                        $display("FAIL data_line: got %h expected %h", dataLine, el);
                    end
                    checks++;
                    if (line_tag !== et) begin
                        errors++;
                        $display("FAIL line_tag: got %h expected %h", line_tag, et);
                    end
                end
                if (chain) start_miss(next_addr, 1'b1);
                else miss = 1'b0;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL line_timeout: no line_valid within %0d cycles, expected latency %0d", n, exp_lat);
        end
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", n, exp_lat);
        end
        checks++;
        if (first_rd != exp_first_rd) begin
            errors++;
            $display("FAIL mem_rd_rise: got cycle %0d expected %0d", first_rd, exp_first_rd);
        end
        checks++;
        if (hold != exp_hold) begin
            errors++;
            $display("FAIL addr_hold: beat1 address held %0d cycles expected %0d", hold, exp_hold);
        end
        checks++;
        if (seen.size() != 4) begin
            errors++;
            $display("FAIL beat_count: got %0d beats expected 4", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            ea = base + 16'(2 * i);
            checks++;
            if (seen[i] !== ea) begin
                errors++;
                $display("FAIL mem_addr_beat%0d: got %h expected %h", i, seen[i], ea);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (line_valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL %s: line_valid=%b busy=%b mem_rd=%b expected 0 0 0", tag, line_valid, busy, mem_rd);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; miss = 1'b0; miss_addr = '0; stall = 1'b0;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_rd, mem_addr, dataLine, line_valid, line_tag, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_values: rd=%b addr=%h line=%h lv=%b tag=%h busy=%b err=%b expected all 0",
                     mem_rd, mem_addr, dataLine, line_valid, line_tag, busy, err);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_no_request: mem_rd/busy high in %0d of 10 cycles, expected 0", bad);
        end
    endtask

    task automatic test_zero_wait();
        start_miss(16'h1236, 1'b1);
        run_line(1, 5, 16'h1230, 1'b0, 16'h0000, 1);
        @(negedge clk);
        check_idle("after_done");
    endtask

    task automatic test_wait_states();
        waits[1] = 2;
        start_miss(16'h1236, 1'b1);
        run_line(1, 7, 16'h1230, 1'b0, 16'h0000, 3);
        waits[1] = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lv;
        start_miss(16'h1236, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        miss  = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || line_valid !== 1'b0 || mem_addr !== 16'h0000 || dataLine !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid: rd=%b busy=%b lv=%b addr=%h line=%h expected all 0",
                     mem_rd, busy, line_valid, mem_addr, dataLine);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lv = 0;
        repeat (8) begin
            @(negedge clk);
            if (line_valid) lv++;
        end
        checks++;
        if (lv != 0) begin
            errors++;
            $display("FAIL partial_line_valid: got %0d strobes expected 0", lv);
        end
        start_miss(16'h2A1A, 1'b1);
        run_line(1, 5, 16'h2A18, 1'b0, 16'h0000, 1);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        start_miss(16'h0040, 1'b1);
        run_line(1, 5, 16'h0040, 1'b1, 16'hFFF8, 1);
        run_line(2, 6, 16'hFFF8, 1'b0, 16'h0000, 1);
        @(negedge clk);
        check_idle("after_back_to_back");
    endtask

    task automatic test_stall();
        int n, err_n, lv, rd_at_err;
        stall = 1'b1;
        start_miss(16'h3000, 1'b0);
        n = 0; err_n = -1; lv = 0; rd_at_err = -1;
`ifdef REFILL_TIMEOUT_EN
        while (n < 40 && err_n < 0) begin
            @(negedge clk);
            n++;
            if (line_valid) lv++;
            if (err) begin
                err_n     = n;
                rd_at_err = int'(mem_rd);
            end
        end
        checks++;
        if (err_n != 16) begin
            errors++;
            $display("FAIL err_timing: err at cycle %0d expected 16", err_n);
        end
        checks++;
        if (rd_at_err != 0) begin
            errors++;
            $display("FAIL err_mem_rd: mem_rd=%0d during err expected 0", rd_at_err);
        end
        checks++;
        if (lv != 0) begin
            errors++;
            $display("FAIL abort_line_valid: got %0d strobes expected 0", lv);
        end
        stall = 1'b0;
        start_miss(16'h3000, 1'b1);
        run_line(1, 5, 16'h3000, 1'b0, 16'h0000, 1);
        @(negedge clk);
`else
        repeat (30) begin
            @(negedge clk);
            n++;
            if (line_valid) lv++;
            if (err) err_n = n;
        end
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h3000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: rd=%b addr=%h busy=%b expected 1 3000 1", mem_rd, mem_addr, busy);
        end
        checks++;
        if (err_n >= 0 || lv != 0 || rd_at_err != -1) begin
            errors++;
            $display("FAIL stall_no_abort: err at cycle %0d, %0d strobes, expected none", err_n, lv);
        end
        rst_n = 1'b0;
        miss  = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
        test_stall();
        checks++;
        if (exp_line_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d lines never delivered, expected 0", exp_line_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
